phoenix_vc_buffer: RTL and testbench
====================================

# phoenix_vc_buffer

Parametrised input buffer for a Phoenix NoC router port with NUM_VC virtual channels, each holding an independent flit FIFO. Per-VC credit flow control sits on the receive side. A packet-aware state machine selects a VC with a header at its head (round-robin), requests routing from the switch control, then streams the whole packet (header, size, payload) to the crossbar. It replaces the single-channel input buffer on every router port and runs entirely in the router clock domain.

## Interface
- TAM_FLIT, 16: flit width in bits.
- DEPTH, 4: flits per VC FIFO (≥2, power of two).
- NUM_VC, 2: virtual channels (≥1); VCW = max(1, $clog2(NUM_VC)).

- clock  in  1  router clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rx  in  1  flit valid from upstream.
- vc_in  in  VCW  VC of incoming flit.
- data_in  in  TAM_FLIT  incoming flit.
- credit_o  out  NUM_VC  per-VC credit: FIFO may accept a flit this cycle.
- h  out  1  routing request, header at head of vc_sel.
- ack_h  in  1  routing granted.
- data_av  out  1  flit valid toward crossbar.
- data  out  TAM_FLIT  head flit of vc_sel.
- data_ack  in  1  crossbar consumed data this cycle.
- vc_sel  out  VCW  VC currently requesting/sending.
- sender  out  1  high while in SEND.
- overflow  out  NUM_VC  sticky: flit arrived on a VC with no credit.

## Operation
- Per-VC FIFO: count 0..DEPTH ($clog2(DEPTH)+1 bits); rd/wr pointers wrap modulo DEPTH.
- push[v] = rx & vc_in==v; pop[v] = data_av & data_ack & vc_sel==v.
- credit_o[v] = (count[v]!=DEPTH) | pop[v] (combinational).
- Push while full and no pop on that VC: flit discarded, overflow[v] set until reset.
- Push with vc_in ≥ NUM_VC: ignored, no flag.
- Push and pop on same VC same cycle: count unchanged, both pointers advance; legal when full.
- Packet format: flit 0 header, flit 1 size N (unsigned, full flit), then N payload flits; total N+2.
- FSM states:
  - IDLE: round-robin scan from rr_ptr for first VC with count≠0; if found, latch vc_sel and go REQ.
  - REQ: h=1. On ack_h go SEND.
  - SEND: data_av = (count[vc_sel]≠0). Each pop advances flit_idx; on pop of flit 1 load remaining=N; each later pop decrements remaining. Last flit is flit 1 when N=0, else the pop where remaining==1. After last-flit pop: rr_ptr = vc_sel+1 mod NUM_VC, go IDLE.
- vc_sel is stable from IDLE→REQ until return to IDLE. Other VCs keep accepting flits throughout.
- data = head of FIFO[vc_sel] at all times. data_av and pop are gated to SEND.
- Payload gaps (empty FIFO mid-packet): data_av low; stay in SEND.

## Timing
- Reset (reset==0 at an edge): all counts/pointers 0, state IDLE, rr_ptr 0, vc_sel 0, overflow 0, flit_idx/remaining 0. Hence h=0, data_av=0, sender=0, credit_o all 1.
- Write latency: flit pushed at edge k is visible at head (count≠0) after edge k.
- IDLE→REQ costs one cycle; h is asserted the cycle after a header becomes visible.
- ack_h sampled only in REQ. Earliest data_av is the cycle after ack_h.
- One flit per cycle max; full-rate streaming when data_ack is held high.
- Return to IDLE one cycle after last pop. Next packet's h is no earlier than 2 cycles after the last pop.
- Reset mid-packet: packet state and FIFO contents are lost; no partial resend.

## Structure
- Shared package/defines (defines.vh): TAM_FLIT default, buffer depth default, NUM_VC default, FSM state encodings (S_IDLE, S_REQ, S_SEND).
- One sub-module: phoenix_vc_fifo (single-clock FIFO with count, push/pop, head), instantiated NUM_VC times via generate. Arbitration, FSM and packet counter live in phoenix_vc_buffer.

## Test plan
- Reset: hold reset=0 for 2 cycles → credit_o=all ones, h=0, data_av=0, overflow=0.
- Single packet VC0, NUM_VC=2: header 0x0011, size 0x0002, payloads 0xAAAA/0xBBBB; ack_h one cycle after h; data_ack held → 4 flits in order on consecutive cycles; sender drops after 4th pop; count[0]=0.
- Zero-size packet: header then size 0x0000 → exactly 2 flits delivered, FSM back to IDLE.
- Round-robin: packets queued on VC0 and VC1 simultaneously → VC0 served first, then VC1, then VC0 again on refill.
- Full/credit: push DEPTH flits into VC1 with no drain → credit_o[1]=0. Extra push sets overflow[1] and count stays DEPTH. Push with same-cycle pop at full → accepted, no overflow.
- Interleaved arrival: VC1 flits arrive while VC0 streams with data_ack toggling → VC0 packet intact with stalls respected. VC1 is requested only after VC0's last flit. Reset asserted mid-VC0 packet returns to the reset values.

Source files
------------

// File: rtl/phoenix_vc_buffer_pkg.sv
// Phoenix VC input buffer: shared defaults, FSM encodings
// and the VC index width helper.
package phoenix_vc_buffer_pkg;

  localparam int TAM_FLIT_DEF = 16;
  localparam int DEPTH_DEF    = 4;
  localparam int NUM_VC_DEF   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  // Position inside the packet being streamed
  typedef enum logic [1:0] {
    F_HDR  = 2'd0,
    F_SIZE = 2'd1,
    F_PAY  = 2'd2
  } fidx_t;

  function automatic int vc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phoenix_vc_buffer_if.sv
// Phoenix VC input buffer port bundle: upstream flits,
// credits, routing request and crossbar stream.
interface phoenix_vc_buffer_if
  import phoenix_vc_buffer_pkg::*;
#(
  parameter int TAM_FLIT = TAM_FLIT_DEF,
  parameter int NUM_VC   = NUM_VC_DEF
);
  localparam int VCW = vc_width(NUM_VC);

  logic                rx;
  logic [VCW-1:0]      vc_in;
  logic [TAM_FLIT-1:0] data_in;
  logic [NUM_VC-1:0]   credit_o;
  logic                h;
  logic                ack_h;
  logic                data_av;
  logic [TAM_FLIT-1:0] data;
  logic                data_ack;
  logic [VCW-1:0]      vc_sel;
  logic                sender;
  logic [NUM_VC-1:0]   overflow;

  modport master (
    output rx, vc_in, data_in,
    output ack_h, data_ack,
    input  credit_o, h, data_av,
    input  data, vc_sel, sender,
    input  overflow
  );

  modport slave (
    input  rx, vc_in, data_in,
    input  ack_h, data_ack,
    output credit_o, h, data_av,
    output data, vc_sel, sender,
    output overflow
  );

endinterface

// File: rtl/phoenix_vc_fifo.sv
// Single-clock flit FIFO for one virtual channel,
// exposing occupancy and the head flit.
module phoenix_vc_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          rd_en;
  logic          wr_en;

  assign full  = count == CW'(DEPTH);
  assign rd_en = pop && (count != '0);
  // A full FIFO still takes a flit when its head leaves
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/phoenix_vc_buffer.sv
// Phoenix router input port: per-VC FIFOs with credits,
// round-robin packet selection and packet streaming FSM.
module phoenix_vc_buffer
  import phoenix_vc_buffer_pkg::*;
#(
  parameter int TAM_FLIT = TAM_FLIT_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_VC   = NUM_VC_DEF
) (
  input logic               clock,
  input logic               reset,
  phoenix_vc_buffer_if.slave bus
);

  localparam int VCW = vc_width(NUM_VC);
  localparam int CW  = $clog2(DEPTH) + 1;

  state_t              state;
  fidx_t               flit_idx;
  logic [TAM_FLIT-1:0] remaining;
  logic [VCW-1:0]      rr_ptr;
  logic [VCW-1:0]      vc_sel;
  logic [VCW-1:0]      next_vc;
  logic                found;
  logic [NUM_VC-1:0]   push;
  logic [NUM_VC-1:0]   pop;
  logic [NUM_VC-1:0]   ne;
  logic [NUM_VC-1:0]   full;
  logic [NUM_VC-1:0]   credit;
  logic [NUM_VC-1:0]   ovf;
  logic [CW-1:0]       cnt  [NUM_VC];
  logic [TAM_FLIT-1:0] head [NUM_VC];
  logic [TAM_FLIT-1:0] head_sel;
  logic                av;
  logic                fire;
  logic                last;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push[v]   = bus.rx && (bus.vc_in == VCW'(v));
    assign pop[v]    = fire && (vc_sel == VCW'(v));
    assign ne[v]     = cnt[v] != '0;
    assign full[v]   = cnt[v] == CW'(DEPTH);
    assign credit[v] = !full[v] || pop[v];

    phoenix_vc_fifo #(
      .W     (TAM_FLIT),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (bus.data_in),
      .head  (head[v]),
      .count (cnt[v])
    );
  end

  assign head_sel = head[vc_sel];
  assign av       = (state == S_SEND) && ne[vc_sel];
  assign fire     = av && bus.data_ack;

  // Walk downward so the VC closest to rr_ptr wins
  always_comb begin
    int             j;
    logic [VCW-1:0] idx;
    found   = 1'b0;
    next_vc = rr_ptr;
    j       = 0;
    idx     = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_VC) j = j - NUM_VC;
      idx = VCW'(j);
      if (ne[idx]) begin
        found   = 1'b1;
        next_vc = idx;
      end
    end
  end

  always_comb begin
    last = 1'b0;
    unique case (flit_idx)
      F_SIZE:  last = head_sel == '0;
      F_PAY:   last = remaining == TAM_FLIT'(1);
      default: last = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      vc_sel    <= '0;
      rr_ptr    <= '0;
      flit_idx  <= F_HDR;
      remaining <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            vc_sel <= next_vc;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.ack_h) state <= S_SEND;
        end
        S_SEND: begin
          if (fire) begin
            if (last) begin
              state     <= S_IDLE;
              flit_idx  <= F_HDR;
              remaining <= '0;
              rr_ptr    <= (vc_sel == VCW'(NUM_VC - 1))
                           ? '0 : vc_sel + VCW'(1);
            end else begin
              unique case (flit_idx)
                F_HDR:   flit_idx <= F_SIZE;
                F_SIZE: begin
                  flit_idx  <= F_PAY;
                  remaining <= head_sel;
                end
                default: remaining <= remaining - TAM_FLIT'(1);
              endcase
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) ovf <= '0;
    else        ovf <= ovf | (push & full & ~pop);
  end

  assign bus.credit_o = credit;
  assign bus.h        = state == S_REQ;
  assign bus.data_av  = av;
  assign bus.data     = head_sel;
  assign bus.vc_sel   = vc_sel;
  assign bus.sender   = state == S_SEND;
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_phoenix_vc_buffer.sv
// Directed bench for phoenix_vc_buffer: reset, streaming,
// zero-size, round-robin, credit/overflow, interleave, reset.
module tb_phoenix_vc_buffer;
  import phoenix_vc_buffer_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  phoenix_vc_buffer_if #(.TAM_FLIT(16), .NUM_VC(2)) bus ();

  phoenix_vc_buffer #(
    .TAM_FLIT (16),
    .DEPTH    (4),
    .NUM_VC   (2)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] p1 [4] = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
  logic        a4 [8] = '{1, 0, 1, 0, 1, 1, 0, 1};
  logic        r4 [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
  logic        v4 [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
  logic [15:0] d4 [8] = '{16'h0066, 16'h5503, 16'h0000, 16'h0,
                          16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] x4 [8] = '{16'h0055, 16'h0003, 16'h0003, 16'h5501,
                          16'h5501, 16'h5502, 16'h5503, 16'h5503};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic vc,
                       input logic [15:0] d);
    bus.rx      = r;
    bus.vc_in   = vc;
    bus.data_in = d;
  endtask

  task automatic push(input logic vc, input logic [15:0] d);
    drive(1'b1, vc, d);
    cyc();
    drive(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.ack_h    = 1'b0;
    bus.data_ack = 1'b0;
    drive(1'b0, 1'b0, 16'h0);

    // reset
    repeat (2) cyc();
    chk("rst_credit", bus.credit_o, 2'b11);
    chk("rst_h", bus.h, 0);
    chk("rst_av", bus.data_av, 0);
    chk("rst_ovf", bus.overflow, 2'b00);
    chk("rst_sender", bus.sender, 0);
    rst_n = 1'b1;

    // single packet on VC0
    push(1'b0, 16'h0011);
    push(1'b0, 16'h0002);
    push(1'b0, 16'hAAAA);
    push(1'b0, 16'hBBBB);
    #1;
    chk("p1_h", bus.h, 1);
    chk("p1_vcsel", bus.vc_sel, 0);
    chk("p1_head", bus.data, 16'h0011);
    chk("p1_av_req", bus.data_av, 0);
    chk("p1_credit_full", bus.credit_o, 2'b10);
    bus.ack_h = 1'b1;
    cyc();
    bus.ack_h    = 1'b0;
    bus.data_ack = 1'b1;
    #1;
    chk("p1_credit_pop", bus.credit_o, 2'b11);
    chk("p1_sender", bus.sender, 1);
    chk("p1_h_send", bus.h, 0);
    for (int i = 0; i < 4; i++) begin
      chk("p1_av", bus.data_av, 1);
      chk("p1_data", bus.data, p1[i]);
      cyc();
    end
    bus.data_ack = 1'b0;
    #1;
    chk("p1_sender_end", bus.sender, 0);
    chk("p1_av_end", bus.data_av, 0);
    chk("p1_cnt0", dut.cnt[0], 0);

    // zero-size on VC1 held in REQ while both VCs fill
    push(1'b1, 16'h0022);
    push(1'b1, 16'h0000);
    push(1'b1, 16'h0B00);
    push(1'b1, 16'h0000);
    push(1'b0, 16'h0A00);
    push(1'b0, 16'h0001);
    push(1'b0, 16'h0A01);
    #1;
    chk("p2_h", bus.h, 1);
    chk("p2_vcsel", bus.vc_sel, 1);
    chk("p2_head", bus.data, 16'h0022);
    chk("p2_credit", bus.credit_o, 2'b01);
    chk("p2_ovf", bus.overflow, 2'b00);
    bus.ack_h = 1'b1;
    cyc();
    bus.ack_h    = 1'b0;
    bus.data_ack = 1'b1;
    #1;
    chk("z_d0", bus.data, 16'h0022);
    cyc();
    chk("z_d1", bus.data, 16'h0000);
    chk("z_av1", bus.data_av, 1);
    cyc();
    bus.data_ack = 1'b0;
    #1;
    chk("z_sender_end", bus.sender, 0);
    chk("z_h_gap", bus.h, 0);
    cyc();
    chk("rr_vc0_h", bus.h, 1);
    chk("rr_vc0_sel", bus.vc_sel, 0);
    chk("rr_vc0_head", bus.data, 16'h0A00);
    bus.ack_h = 1'b1;
    cyc();
    bus.ack_h    = 1'b0;
    bus.data_ack = 1'b1;
    drive(1'b1, 1'b0, 16'h0C00);
    #1;
    chk("rr_a0", bus.data, 16'h0A00);
    cyc();
    drive(1'b1, 1'b0, 16'h0000);
    #1;
    chk("rr_a1", bus.data, 16'h0001);
    cyc();
    drive(1'b0, 1'b0, 16'h0);
    #1;
    chk("rr_a2", bus.data, 16'h0A01);
    cyc();
    bus.data_ack = 1'b0;
    cyc();
    chk("rr_vc1_h", bus.h, 1);
    chk("rr_vc1_sel", bus.vc_sel, 1);
    chk("rr_vc1_head", bus.data, 16'h0B00);
    bus.ack_h = 1'b1;
    cyc();
    bus.ack_h    = 1'b0;
    bus.data_ack = 1'b1;
    #1;
    chk("rr_b0", bus.data, 16'h0B00);
    cyc();
    chk("rr_b1", bus.data, 16'h0000);
    cyc();
    bus.data_ack = 1'b0;
    cyc();
    chk("rr_vc0b_sel", bus.vc_sel, 0);
    chk("rr_vc0b_head", bus.data, 16'h0C00);
    bus.ack_h = 1'b1;
    cyc();
    bus.ack_h    = 1'b0;
    bus.data_ack = 1'b1;
    #1;
    chk("rr_c0", bus.data, 16'h0C00);
    cyc();
    chk("rr_c1", bus.data, 16'h0000);
    cyc();
    bus.data_ack = 1'b0;
    #1;
    chk("rr_sender_end", bus.sender, 0);

    // full, credit, overflow on VC1
    push(1'b1, 16'h0033);
    push(1'b1, 16'h0002);
    push(1'b1, 16'h3331);
    push(1'b1, 16'h3332);
    #1;
    chk("f_credit", bus.credit_o, 2'b01);
    chk("f_ovf0", bus.overflow, 2'b00);
    chk("f_sel", bus.vc_sel, 1);
    bus.ack_h = 1'b1;
    cyc();
    bus.ack_h    = 1'b0;
    bus.data_ack = 1'b1;
    drive(1'b1, 1'b1, 16'h0044);
    #1;
    chk("f_credit_pop", bus.credit_o, 2'b11);
    chk("f_head", bus.data, 16'h0033);
    cyc();
    bus.data_ack = 1'b0;
    drive(1'b1, 1'b1, 16'hDEAD);
    #1;
    chk("f_ovf_pp", bus.overflow, 2'b00);
    chk("f_credit_nopop", bus.credit_o, 2'b01);
    cyc();
    drive(1'b0, 1'b0, 16'h0);
    #1;
    chk("f_ovf1", bus.overflow, 2'b10);
    chk("f_cnt1", dut.cnt[1], 4);
    chk("f_head2", bus.data, 16'h0002);
    bus.data_ack = 1'b1;
    #1;
    chk("f_d1", bus.data, 16'h0002);
    cyc();
    chk("f_d2", bus.data, 16'h3331);
    cyc();
    chk("f_d3", bus.data, 16'h3332);
    cyc();
    bus.data_ack = 1'b0;
    #1;
    chk("f_cnt1_left", dut.cnt[1], 1);
    chk("f_sender_end", bus.sender, 0);
    cyc();
    chk("f_next_h", bus.h, 1);
    chk("f_next_head", bus.data, 16'h0044);
    drive(1'b1, 1'b1, 16'h0000);
    bus.ack_h = 1'b1;
    cyc();
    drive(1'b0, 1'b0, 16'h0);
    bus.ack_h    = 1'b0;
    bus.data_ack = 1'b1;
    #1;
    chk("f_e0", bus.data, 16'h0044);
    cyc();
    chk("f_e1", bus.data, 16'h0000);
    cyc();
    bus.data_ack = 1'b0;
    #1;
    chk("f_e_sender", bus.sender, 0);
    chk("f_ovf_sticky", bus.overflow, 2'b10);

    // interleaved arrival with toggling data_ack
    push(1'b0, 16'h0055);
    push(1'b0, 16'h0003);
    push(1'b0, 16'h5501);
    push(1'b0, 16'h5502);
    #1;
    chk("i_sel", bus.vc_sel, 0);
    bus.ack_h = 1'b1;
    cyc();
    bus.ack_h = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.data_ack = a4[i];
      drive(r4[i], v4[i], d4[i]);
      #1;
      chk("i_av", bus.data_av, 1);
      chk("i_data", bus.data, x4[i]);
      chk("i_h", bus.h, 0);
      cyc();
    end
    bus.data_ack = 1'b0;
    drive(1'b0, 1'b0, 16'h0);
    #1;
    chk("i_av_end", bus.data_av, 0);
    chk("i_sender_end", bus.sender, 0);
    chk("i_h_end", bus.h, 0);
    cyc();
    chk("i_vc1_h", bus.h, 1);
    chk("i_vc1_sel", bus.vc_sel, 1);
    chk("i_vc1_head", bus.data, 16'h0066);

    // reset mid-packet
    bus.ack_h = 1'b1;
    cyc();
    bus.ack_h    = 1'b0;
    bus.data_ack = 1'b1;
    #1;
    chk("m_d0", bus.data, 16'h0066);
    cyc();
    bus.data_ack = 1'b0;
    rst_n        = 1'b0;
    cyc();
    chk("m_credit", bus.credit_o, 2'b11);
    chk("m_h", bus.h, 0);
    chk("m_av", bus.data_av, 0);
    chk("m_sender", bus.sender, 0);
    chk("m_ovf", bus.overflow, 2'b00);
    chk("m_sel", bus.vc_sel, 0);
    chk("m_cnt1", dut.cnt[1], 0);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("m_h_after", bus.h, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
